updown_count_monitor: RTL and testbench



---
 rtl/updown_count_monitor.sv | 173 +++++++++++++++++
 tb/tb_updown_count_monitor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/updown_count_monitor.sv
// updown_count_monitor: passive observer for an up/down counter's count bus.
// Infers the counting direction, pulses on legal wraps, reversals and illegal
// jumps, and keeps a saturating tally of jumps seen while locked.
// Optional build macro MON_EXPECT_LOAD_EN adds ld_in/load_val so that a
// parallel load is checked against the loaded value instead of being
// classified as a jump.
module updown_count_monitor #(
    parameter int WIDTH = 3,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] count_in,
`ifdef MON_EXPECT_LOAD_EN
    input  logic             ld_in,
    input  logic [WIDTH-1:0] load_val,
`endif
    output logic             dir_up,
    output logic             dir_down,
    output logic             wrap_pulse,
    output logic             rev_pulse,
    output logic             jump_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_ACQ  = 2'd1;
    localparam logic [1:0] ST_UP   = 2'd2;
    localparam logic [1:0] ST_DOWN = 2'd3;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             wrap_q, wrap_d;
    logic             rev_q, rev_d;
    logic             jump_q, jump_d;

    logic [WIDTH-1:0] delta;
    logic             is_up, is_dn, is_hold;
    logic             err_inc;

`ifdef MON_EXPECT_LOAD_EN
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             ld_pend_q, ld_pend_d;
`endif

    // Classify each sample against the previous one and compute next state.
    always_comb begin
        delta   = count_in - prev_q;
        is_up   = (delta == CNT_ONE);
        is_dn   = (delta == CNT_MAX);
        is_hold = (delta == '0);

        state_d = state_q;
        prev_d  = prev_q;
        err_d   = err_q;
        wrap_d  = 1'b0;
        rev_d   = 1'b0;
        jump_d  = 1'b0;
        err_inc = 1'b0;
`ifdef MON_EXPECT_LOAD_EN
        exp_d     = exp_q;
        ld_pend_d = ld_pend_q;
`endif

        if (sample_en) begin
            prev_d = count_in;
            // Direction test order matters only for WIDTH=1, where a step
            // satisfies both: DOWN checks STEP_DN first so it never reverses.
            case (state_q)
                ST_INIT: state_d = ST_ACQ;
                ST_ACQ: begin
                    if (is_up)         state_d = ST_UP;
                    else if (is_dn)    state_d = ST_DOWN;
                    else if (!is_hold) jump_d  = 1'b1;
                end
                ST_UP: begin
                    if (is_up) begin
                        wrap_d = (prev_q == CNT_MAX);
                    end else if (is_dn) begin
                        state_d = ST_DOWN;
                        rev_d   = 1'b1;
                        wrap_d  = (prev_q == '0);
                    end else if (!is_hold) begin
                        state_d = ST_ACQ;
                        jump_d  = 1'b1;
                        err_inc = 1'b1;
                    end
                end
                default: begin // ST_DOWN
                    if (is_dn) begin
                        wrap_d = (prev_q == '0);
                    end else if (is_up) begin
                        state_d = ST_UP;
                        rev_d   = 1'b1;
                        wrap_d  = (prev_q == CNT_MAX);
                    end else if (!is_hold) begin
                        state_d = ST_ACQ;
                        jump_d  = 1'b1;
                        err_inc = 1'b1;
                    end
                end
            endcase
`ifdef MON_EXPECT_LOAD_EN
            // A pending load check overrides the step classification.
            if (ld_pend_q) begin
                state_d   = ST_ACQ;
                wrap_d    = 1'b0;
                rev_d     = 1'b0;
                jump_d    = (count_in != exp_q);
                err_inc   = (count_in != exp_q);
                ld_pend_d = 1'b0;
            end
`endif
        end

`ifdef MON_EXPECT_LOAD_EN
        // A new strobe re-arms the check even if one is consumed this edge.
        if (ld_in) begin
            exp_d     = load_val;
            ld_pend_d = 1'b1;
        end
`endif

        if (err_inc && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    // Register state, history, tally and pulses; synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            prev_q  <= '0;
            err_q   <= '0;
            wrap_q  <= 1'b0;
            rev_q   <= 1'b0;
            jump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
            rev_q   <= rev_d;
            jump_q  <= jump_d;
        end
    end

`ifdef MON_EXPECT_LOAD_EN
    // Register the expected load value and its one-shot check flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q     <= '0;
            ld_pend_q <= 1'b0;
        end else begin
            exp_q     <= exp_d;
            ld_pend_q <= ld_pend_d;
        end
    end
`endif

    assign dir_up     = (state_q == ST_UP);
    assign dir_down   = (state_q == ST_DOWN);
    assign wrap_pulse = wrap_q;
    assign rev_pulse  = rev_q;
    assign jump_pulse = jump_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_updown_count_monitor.sv
// Directed bench for updown_count_monitor (WIDTH=3, ERR_W=4): a vector table
// plus hand-written sequences for gaps, mid-stream reset, saturation and,
// when MON_EXPECT_LOAD_EN is defined, load checking.
module tb_updown_count_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_en = 1'b0;
    logic [2:0] count_in = '0;
    logic       ld_in = 1'b0;
    logic [2:0] load_val = '0;
    logic       dir_up, dir_down, wrap_pulse, rev_pulse, jump_pulse;
    logic [3:0] err_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    updown_count_monitor #(.WIDTH(3), .ERR_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_en  (sample_en),
        .count_in   (count_in),
`ifdef MON_EXPECT_LOAD_EN
        .ld_in      (ld_in),
        .load_val   (load_val),
`endif
        .dir_up     (dir_up),
        .dir_down   (dir_down),
        .wrap_pulse (wrap_pulse),
        .rev_pulse  (rev_pulse),
        .jump_pulse (jump_pulse),
        .err_count  (err_count)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] cnt;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Expected output word: {du, dd, wrap, rev, jump, err[3:0]}.
    function automatic logic [8:0] e(input logic du, input logic dd, input logic wr,
                                     input logic rv, input logic jp, input logic [3:0] er);
        return {du, dd, wr, rv, jp, er};
    endfunction

    function automatic void v(input logic rst, input logic en, input logic [2:0] cnt,
                              input logic [8:0] exp);
        vec_t r;
        r.rst = rst; r.en = en; r.cnt = cnt; r.exp = exp;
        tbl.push_back(r);
    endfunction

    // Called at a negedge: apply inputs, cross one rising edge, return at negedge.
    task automatic drive(input logic rst, input logic en, input logic [2:0] cnt);
        reset = rst; sample_en = en; count_in = cnt;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [8:0] exp);
        logic [8:0] got;
        got = {dir_up, dir_down, wrap_pulse, rev_pulse, jump_pulse, err_count};
        total++;
        if (got !== exp)
            $display("FAIL %s: got du/dd/wr/rv/jp/err=%b  expected %b", name, got, exp);
        else
            passed++;
    endtask

    initial begin
        int unsigned cur;
        int unsigned exp_err;

        // Reset and count 0..7,0
        v(1, 0, 0, e(0,0,0,0,0,0));
        v(0, 1, 0, e(0,0,0,0,0,0));
        for (int i = 1; i <= 7; i++) v(0, 1, 3'(i), e(1,0,0,0,0,0));
        v(0, 1, 0, e(1,0,1,0,0,0));
        for (int i = 1; i <= 5; i++) v(0, 1, 3'(i), e(1,0,0,0,0,0));
        // Reverse at 5 -> 4, then down through the 0->7 wrap
        v(0, 1, 4, e(0,1,0,1,0,0));
        v(0, 1, 3, e(0,1,0,0,0,0));
        v(0, 1, 2, e(0,1,0,0,0,0));
        v(0, 1, 1, e(0,1,0,0,0,0));
        v(0, 1, 0, e(0,1,0,0,0,0));
        v(0, 1, 7, e(0,1,1,0,0,0));
        v(0, 1, 6, e(0,1,0,0,0,0));
        // Reverse back up, wrap, then an illegal jump from 2 to 6
        v(0, 1, 7, e(1,0,0,1,0,0));
        v(0, 1, 0, e(1,0,1,0,0,0));
        v(0, 1, 1, e(1,0,0,0,0,0));
        v(0, 1, 2, e(1,0,0,0,0,0));
        v(0, 1, 6, e(0,0,0,0,1,1));
        v(0, 1, 7, e(1,0,0,0,0,1));
        v(0, 1, 0, e(1,0,1,0,0,1));
        v(0, 1, 0, e(1,0,0,0,0,1));
        // Reversals that are also wraps
        v(0, 1, 7, e(0,1,1,1,0,1));
        v(0, 1, 0, e(1,0,1,1,0,1));
        // Reset clears tally; jump in ACQ pulses without counting
        v(1, 1, 3, e(0,0,0,0,0,0));
        v(0, 1, 0, e(0,0,0,0,0,0));
        v(0, 1, 4, e(0,0,0,0,1,0));
        v(0, 1, 4, e(0,0,0,0,0,0));
        v(0, 1, 3, e(0,1,0,0,0,0));
        v(0, 0, 5, e(0,1,0,0,0,0));
        v(0, 1, 2, e(0,1,0,0,0,0));

        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].cnt);
            chk($sformatf("vec[%0d]", i), tbl[i].exp);
        end

        // sample_en gap with random count_in, then resume at prev+1
        drive(1, 0, 0);
        drive(0, 1, 0);
        drive(0, 1, 1);
        drive(0, 1, 2);
        chk("gap_pre", e(1,0,0,0,0,0));
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 3'($urandom_range(0, 7)));
            chk($sformatf("gap[%0d]", i), e(1,0,0,0,0,0));
        end
        drive(0, 1, 3);
        chk("gap_resume", e(1,0,0,0,0,0));

        // Mid-stream reset returns to INIT: first sample afterwards is silent
        drive(1, 1, 4);
        chk("mid_reset", e(0,0,0,0,0,0));
        drive(0, 1, 6);
        chk("init_first", e(0,0,0,0,0,0));
        drive(0, 1, 7);
        chk("init_relock", e(1,0,0,0,0,0));

        // Error tally saturation: 20 jumps from UP, relocking after each
        drive(1, 0, 0);
        drive(0, 1, 0);
        drive(0, 1, 1);
        cur = 1;
        exp_err = 0;
        for (int i = 0; i < 20; i++) begin
            cur = (cur + 4) % 8;
            drive(0, 1, 3'(cur));
            if (exp_err < 15) exp_err++;
            chk($sformatf("sat_jump[%0d]", i), e(0,0,0,0,1,4'(exp_err)));
            cur = (cur + 1) % 8;
            drive(0, 1, 3'(cur));
            chk($sformatf("sat_relock[%0d]", i), e(1,0,0,0,0,4'(exp_err)));
        end

`ifdef MON_EXPECT_LOAD_EN
        // Legal load while locked UP at 1
        drive(1, 0, 0);
        drive(0, 1, 0);
        drive(0, 1, 1);
        ld_in = 1'b1; load_val = 3'd5;
        drive(0, 0, 1);
        ld_in = 1'b0;
        chk("ld_strobe", e(1,0,0,0,0,0));
        drive(0, 1, 5);
        chk("ld_match", e(0,0,0,0,0,0));
        drive(0, 1, 6);
        chk("ld_relock", e(1,0,0,0,0,0));
        // Mismatched load: sample 6 against expected 5
        ld_in = 1'b1; load_val = 3'd5;
        drive(0, 0, 6);
        ld_in = 1'b0;
        drive(0, 1, 6);
        chk("ld_mismatch", e(0,0,0,0,1,1));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
